// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner: steps one digit per scan_clk rise, with a shadow register that commits at frame end.
// Latency: an/seg/dp are registered, one clk after idx/disp change. load_ack follows the committing tick by one clk.
// Backpressure: none. load is always accepted; a pending shadow is overwritten (last write wins), busy flags it.
//
// Ports:
//   clk, rst (async, active-low), scan_clk (divided clock, same clk domain)
//   digits_in / dp_in / load  -> shadow capture
//   busy, load_ack            -> commit status
//   seg, dp, an               -> display drive (polarity set by parameters)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the highest nonzero digit.
module seven_seg_scanner #(
   parameter int N_DIGITS       = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scan_clk,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  load,
   output logic                  busy,
   output logic                  load_ack,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an
);

   localparam int               IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [6:0]       SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic             DP_OFF   = SEG_ACTIVE_LOW;
   localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

   logic                  scan_q;
   logic [IDX_W-1:0]      idx;
   logic [4*N_DIGITS-1:0] shadow;
   logic [N_DIGITS-1:0]   shadow_dp;
   logic [4*N_DIGITS-1:0] disp;
   logic [N_DIGITS-1:0]   disp_dp;

   logic                  tick;
   logic                  commit;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic [N_DIGITS-1:0]   an_onehot;
   logic                  blank;

   // Active-high gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // scan_clk is generated from clk, so a plain edge detect is safe here.
   assign tick   = scan_clk & ~scan_q;
   // Commit only when the last digit of a frame is left, so a frame is never mixed.
   assign commit = tick & (idx == IDX_LAST) & busy;

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      an_onehot = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib      = disp[4*i +: 4];
            cur_dp       = disp_dp[i];
            an_onehot[i] = 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Blank when this digit and every digit above it are zero; digit0 always shows.
   always_comb begin
      blank = (idx != '0);
      for (int i = 0; i < N_DIGITS; i++) begin
         if ((IDX_W'(i) >= idx) && (disp[4*i +: 4] != 4'h0))
            blank = 1'b0;
      end
   end
`else
   always_comb begin
      blank = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_q    <= 1'b0;
         idx       <= '0;
         shadow    <= '0;
         shadow_dp <= '0;
         disp      <= '0;
         disp_dp   <= '0;
         busy      <= 1'b0;
         load_ack  <= 1'b0;
         an        <= AN_OFF;
         seg       <= SEG_OFF;
         dp        <= DP_OFF;
      end else begin
         scan_q   <= scan_clk;
         load_ack <= commit;

         if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

         // disp takes the pre-edge shadow even if load overwrites it in the same cycle.
         if (commit) begin
            disp    <= shadow;
            disp_dp <= shadow_dp;
         end

         if (load) begin
            shadow    <= digits_in;
            shadow_dp <= dp_in;
            busy      <= 1'b1;
         end else if (commit) begin
            busy <= 1'b0;
         end

         an <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
         if (blank) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
         end else begin
            seg <= SEG_ACTIVE_LOW ? ~hex_to_seg(cur_nib) : hex_to_seg(cur_nib);
            dp  <= cur_dp ^ SEG_ACTIVE_LOW;
         end
      end
   end

endmodule
